signed_add_with_overflow_pipe: RTL

Parametrised, carry-pipelined two's-complement adder with overflow detection and an overflow event counter. It is the wide-operand successor of the 4-bit combinational signed adder. The carry chain is split into `STAGES` equal chunks, one register stage per chunk, so wide adds close timing at full throughput. It sits in the datapath between a valid-only producer and consumer; there is no backpressure.

---
 rtl/signed_add_with_overflow_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/signed_add_with_overflow_pipe.sv
// Carry-pipelined signed adder: STAGES chunk adders with skew/deskew registers, overflow flag
// and a saturating overflow counter. Define SIGNED_ADD_SAT_EN to clamp res on overflow.
module signed_add_with_overflow_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             res_vld,
  output logic [W-1:0]     res,
  output logic             overflow,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int CW = W / STAGES;

`ifdef SIGNED_ADD_SAT_EN
  localparam logic [W-1:0] SMIN = W'(1) << (W-1);
  localparam logic [W-1:0] SMAX = ~SMIN;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added when entering stage k (chunk k sits at the bottom).
    localparam int RW = W - k * CW;

    logic [RW-1:0]         a_in;
    logic [RW-1:0]         b_in;
    logic                  c_in;
    logic                  v_in;
    logic [CW-1:0]         chunk_sum;
    logic [(k+1)*CW-1:0]   sum_lo;

    if (k == 0) begin : g_first
      assign a_in   = a;
      assign b_in   = b;
      assign c_in   = 1'b0;
      assign v_in   = arg_vld;
      assign sum_lo = chunk_sum;
    end else begin : g_next
      assign a_in   = g_stage[k-1].g_mid.a_q;
      assign b_in   = g_stage[k-1].g_mid.b_q;
      assign c_in   = g_stage[k-1].g_mid.c_q;
      assign v_in   = g_stage[k-1].g_mid.v_q;
      assign sum_lo = {chunk_sum, g_stage[k-1].g_mid.s_q};
    end

    if (k < STAGES - 1) begin : g_mid
      logic [RW-CW-1:0]    a_q;
      logic [RW-CW-1:0]    b_q;
      logic [(k+1)*CW-1:0] s_q;
      logic                c_q;
      logic                v_q;
      logic                c_nxt;

      assign {c_nxt, chunk_sum} = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + (CW+1)'(c_in);

      always_ff @(posedge clk) begin
        a_q <= a_in[RW-1:CW];
        b_q <= b_in[RW-1:CW];
        s_q <= sum_lo;
        c_q <= c_nxt;
        if (rst) v_q <= 1'b0;
        else     v_q <= v_in;
      end
    end else begin : g_last
      logic [W-1:0] sum;
      logic [W-1:0] res_nxt;
      logic         ovf;

      // Carry out of the MSB is meaningless for a signed result and is dropped here.
      assign chunk_sum = a_in[CW-1:0] + b_in[CW-1:0] + CW'(c_in);
      assign sum       = sum_lo;
      assign ovf       = (a_in[CW-1] == b_in[CW-1]) && (sum[W-1] != a_in[CW-1]);

`ifdef SIGNED_ADD_SAT_EN
      assign res_nxt = ovf ? (a_in[CW-1] ? SMIN : SMAX) : sum;
`else
      assign res_nxt = sum;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          res_vld  <= 1'b0;
          res      <= '0;
          overflow <= 1'b0;
          ovf_cnt  <= '0;
        end else begin
          res_vld <= v_in;
          if (v_in) begin
            res      <= res_nxt;
            overflow <= ovf;
          end
          if (v_in && ovf && (ovf_cnt != {CNT_W{1'b1}}))
            ovf_cnt <= ovf_cnt + 1'b1;
        end
      end
    end
  end

endmodule
